// File: rtl/systolic_setup.sv
// Input-skew stage between the A/B global buffers and the PE array.
// Lane i of each operand word is delayed by i+1 cycles so the array sees a
// diagonal wavefront. Bubble cycles inject zeros. Per-lane valid bits travel
// alongside the data, and a drain counter reports when skew data is still in flight.
module systolic_setup #(
    parameter int ARRAY_N    = 10,
    parameter int DATA_WIDTH = 8
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          ensys_i,
    input  logic                          bubble_i,
    input  logic [ARRAY_N*DATA_WIDTH-1:0] a_word_i,
    input  logic [ARRAY_N*DATA_WIDTH-1:0] b_word_i,
    output logic [ARRAY_N*DATA_WIDTH-1:0] a_skew_o,
    output logic [ARRAY_N*DATA_WIDTH-1:0] b_skew_o,
    output logic [ARRAY_N-1:0]            lane_vld_o,
    output logic                          busy_o
);

    localparam int CNT_W = $clog2(ARRAY_N + 1);

    // A word is taken into the chains only when the feed is enabled and not a bubble.
    logic acc;
    assign acc = ensys_i & ~bubble_i;

    for (genvar i = 0; i < ARRAY_N; i++) begin : g_lane
        // Lane i needs i+1 stages; stage 0 is the head and stage i is the tail.
        logic [DATA_WIDTH-1:0] a_sr [i+1];
        logic [DATA_WIDTH-1:0] b_sr [i+1];
        logic                  v_sr [i+1];

        // Shift the lane chain every cycle; a rejected cycle feeds zeros with valid low.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                // NOTE: the skew chains are cleared on reset because a reset
                // mid-stream must discard in-flight operands; an unreset chain
                // would leak stale elements into the array after release.
                for (int k = 0; k <= i; k++) begin
                    a_sr[k] <= '0;
                    b_sr[k] <= '0;
                    v_sr[k] <= 1'b0;
                end
            end else begin
                // NOTE: non-blocking assignments give every stage the value its
                // predecessor held before the edge, so the loop order is irrelevant.
                a_sr[0] <= acc ? a_word_i[i*DATA_WIDTH +: DATA_WIDTH] : '0;
                b_sr[0] <= acc ? b_word_i[i*DATA_WIDTH +: DATA_WIDTH] : '0;
                v_sr[0] <= acc;
                for (int k = 1; k <= i; k++) begin
                    a_sr[k] <= a_sr[k-1];
                    b_sr[k] <= b_sr[k-1];
                    v_sr[k] <= v_sr[k-1];
                end
            end
        end

        assign a_skew_o[i*DATA_WIDTH +: DATA_WIDTH] = a_sr[i];
        assign b_skew_o[i*DATA_WIDTH +: DATA_WIDTH] = b_sr[i];
        assign lane_vld_o[i]                        = v_sr[i];
    end

    // Drain window: reload on every accept, otherwise count down to zero.
    logic [CNT_W-1:0] drain_cnt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            drain_cnt <= '0;
        end else if (acc) begin
            drain_cnt <= CNT_W'(ARRAY_N);
        end else if (drain_cnt != '0) begin
            drain_cnt <= drain_cnt - CNT_W'(1);
        end
    end

    // The counter is the register, so busy is glitch-free and clears with reset.
    assign busy_o = (drain_cnt != '0);

endmodule

// File: tb/tb_systolic_setup.sv
// Self-checking bench for systolic_setup. A history of every applied word and
// its accept flag is recorded per cycle. The expected outputs in cycle c
// are looked up directly from that history: lane i shows the word from cycle
// c-1-i, and busy is high if any accept happened in the last N cycles.
module tb_systolic_setup;

    localparam int N    = 10;
    localparam int DW   = 8;
    localparam int W    = N * DW;
    localparam int MAXC = 2000;

    logic         clk_i = 1'b0;
    logic         rst_ni = 1'b0;
    logic         ensys_i = 1'b0;
    logic         bubble_i = 1'b0;
    logic [W-1:0] a_word_i = '0;
    logic [W-1:0] b_word_i = '0;
    logic [W-1:0] a_skew_o;
    logic [W-1:0] b_skew_o;
    logic [N-1:0] lane_vld_o;
    logic         busy_o;

    systolic_setup #(.ARRAY_N(N), .DATA_WIDTH(DW)) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .ensys_i    (ensys_i),
        .bubble_i   (bubble_i),
        .a_word_i   (a_word_i),
        .b_word_i   (b_word_i),
        .a_skew_o   (a_skew_o),
        .b_skew_o   (b_skew_o),
        .lane_vld_o (lane_vld_o),
        .busy_o     (busy_o)
    );

    always #5 clk_i = ~clk_i;

    // History of what was applied, one entry per cycle.
    logic         h_acc [MAXC];
    logic [W-1:0] h_a   [MAXC];
    logic [W-1:0] h_b   [MAXC];
    int           cyc     = 0;
    int           floor_c = 0;   // first cycle after the most recent reset release
    int           vectors = 0;
    int           fails   = 0;

    function automatic logic [W-1:0] rand_word();
        logic [W-1:0] w;
        for (int i = 0; i < N; i++) w[i*DW +: DW] = DW'($urandom);
        return w;
    endfunction

    function automatic logic [W-1:0] ramp_word(input int base);
        logic [W-1:0] w;
        for (int i = 0; i < N; i++) w[i*DW +: DW] = DW'(base + i);
        return w;
    endfunction

    function automatic logic [W-1:0] const_word(input int v);
        logic [W-1:0] w;
        for (int i = 0; i < N; i++) w[i*DW +: DW] = DW'(v);
        return w;
    endfunction

    task automatic check_outputs();
        logic [W-1:0] ea;
        logic [W-1:0] eb;
        logic [N-1:0] ev;
        logic         ebusy;
        int           idx;
        ea = '0; eb = '0; ev = '0; ebusy = 1'b0;
        if (rst_ni) begin
            for (int i = 0; i < N; i++) begin
                idx = cyc - 1 - i;
                if (idx >= floor_c && h_acc[idx]) begin
                    ea[i*DW +: DW] = h_a[idx][i*DW +: DW];
                    eb[i*DW +: DW] = h_b[idx][i*DW +: DW];
                    ev[i]          = 1'b1;
                end
            end
            for (int d = 1; d <= N; d++) begin
                idx = cyc - d;
                if (idx >= floor_c && h_acc[idx]) ebusy = 1'b1;
            end
        end
        vectors++;
        assert (a_skew_o === ea) else begin
            fails++;
            $error("FAIL a_skew cyc=%0d observed=%h expected=%h", cyc, a_skew_o, ea);
        end
        vectors++;
        assert (b_skew_o === eb) else begin
            fails++;
            $error("FAIL b_skew cyc=%0d observed=%h expected=%h", cyc, b_skew_o, eb);
        end
        vectors++;
        assert (lane_vld_o === ev) else begin
            fails++;
            $error("FAIL lane_vld cyc=%0d observed=%b expected=%b", cyc, lane_vld_o, ev);
        end
        vectors++;
        assert (busy_o === ebusy) else begin
            fails++;
            $error("FAIL busy cyc=%0d observed=%b expected=%b", cyc, busy_o, ebusy);
        end
    endtask

    // One cycle: set reset level at the falling edge, check outputs, then drive inputs.
    task automatic step(input logic rst, input logic en, input logic bub,
                        input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk_i);
        if (rst && !rst_ni) floor_c = cyc;
        rst_ni = rst;
        #1;
        check_outputs();
        ensys_i  = en;
        bubble_i = bub;
        a_word_i = a;
        b_word_i = b;
        h_acc[cyc] = rst & en & ~bub;
        h_a[cyc]   = a;
        h_b[cyc]   = b;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b1, 1'b0, 1'b0, rand_word(), rand_word());
    endtask

    initial begin
        // Reset held with live, enabled inputs: everything must stay zero.
        for (int k = 0; k < 4; k++) step(1'b0, 1'b1, 1'b0, rand_word(), rand_word());
        // Release with the feed disabled.
        idle(3);

        // Single-word skew.
        step(1'b1, 1'b1, 1'b0, ramp_word(8'h10), ramp_word(8'h80));
        idle(N + 2);

        // Streaming: N back-to-back accepts, A lane value = cycle index.
        for (int j = 0; j < N; j++) step(1'b1, 1'b1, 1'b0, const_word(j), rand_word());
        idle(N + 2);

        // Bubble injection: acc, acc, bubble, acc.
        step(1'b1, 1'b1, 1'b0, rand_word(), rand_word());
        step(1'b1, 1'b1, 1'b0, rand_word(), rand_word());
        step(1'b1, 1'b1, 1'b1, rand_word(), rand_word());
        step(1'b1, 1'b1, 1'b0, rand_word(), rand_word());
        idle(N + 2);

        // Drain after ensys falls.
        step(1'b1, 1'b1, 1'b0, rand_word(), rand_word());
        idle(N + 3);

        // Reset mid-stream three cycles after an accept.
        step(1'b1, 1'b1, 1'b0, ramp_word(8'h40), ramp_word(8'hC0));
        idle(2);
        step(1'b0, 1'b1, 1'b0, rand_word(), rand_word());
        step(1'b0, 1'b1, 1'b0, rand_word(), rand_word());
        idle(N + 2);

        // Random traffic with occasional reset.
        for (int k = 0; k < 300; k++) begin
            step(($urandom_range(0, 99) != 0), ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 3) == 0), rand_word(), rand_word());
        end
        idle(N + 2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule

// File: doc/systolic_setup.md
Name: systolic_setup

Overview:
- Input-skew stage between the global buffers A/B and the PE array.
- Takes one ARRAY_N-element word per cycle from each of buffer A (row operands) and buffer B (column operands). The controller's registered ensys/bubble outputs qualify each word.
- Delays lane i by i extra cycles, so the array sees the diagonal wavefront it needs.
- Replaces bubble cycles with zeros and tracks per-lane validity and a drain window.

Parameters:
- ARRAY_N, 10, number of array rows/columns (lanes per word).
- DATA_WIDTH, 8, bits per operand element.

Ports:
- clk_i  input  1  clock; all state updates on its rising edge.
- rst_ni  input  1  asynchronous active-low reset.
- ensys_i  input  1  systolic feed enable; high while the controller is BUSY.
- bubble_i  input  1  high means the current buffer words are invalid and zeros are injected.
- a_word_i  input  ARRAY_N*DATA_WIDTH  buffer A read data; lane i = bits [i*DATA_WIDTH +: DATA_WIDTH].
- b_word_i  input  ARRAY_N*DATA_WIDTH  buffer B read data; same packing.
- a_skew_o  output  ARRAY_N*DATA_WIDTH  skewed A operands to array row inputs; same packing.
- b_skew_o  output  ARRAY_N*DATA_WIDTH  skewed B operands to array column inputs; same packing.
- lane_vld_o  output  ARRAY_N  bit i high when lane i of both outputs carries a real (non-bubble) element.
- busy_o  output  1  high while any accepted element is still inside the skew registers.

Behaviour:
- Reset: asynchronous and active-low. While rst_ni=0:
  - all skew registers, valid registers and the drain counter clear to 0;
  - a_skew_o=0, b_skew_o=0, lane_vld_o=0, busy_o=0.
  - Reset asserted mid-stream discards all in-flight data immediately. No partial output appears after release.
- Accept condition: acc = ensys_i & ~bubble_i, evaluated each cycle.
- Lane i chain structure:
  - Lane i of A, of B and of the valid chain is a shift chain of i+1 registers, all advancing every cycle with no stall.
  - Chain head loads word[i] if acc, else 0. The valid head loads acc.
  - Outputs are the chain tails. Latency for lane i is i+1 cycles: an element presented at cycle t appears on lane i at cycle t+1+i.
  - Lane 0 latency is 1; lane ARRAY_N-1 latency is ARRAY_N.
- Bubble / ensys low:
  - Zeros are shifted in, and the valid bit is 0.
  - In-flight data continues to drain, so the chains are never frozen or flushed by ensys_i falling.
- Drain counter:
  - Width is ceil(log2(ARRAY_N+1)) bits.
  - Loads ARRAY_N on any acc cycle.
  - Otherwise decrements by 1 when non-zero and holds at 0.
  - busy_o = (counter != 0), registered. It goes high the cycle after the first acc and falls exactly ARRAY_N cycles after the last acc, coinciding with the last lane_vld_o[ARRAY_N-1] pulse ending.
- Simultaneous acc and non-zero counter: the reload wins (counter = ARRAY_N).
- Back-to-back accepts: continuous. ARRAY_N consecutive acc cycles produce a full diagonal wavefront with no gaps.
- Arithmetic: none on data. Elements pass bit-exact, unsigned/signed agnostic.
- Total state: ARRAY_N*(ARRAY_N+1)/2 registers per data chain per bit, plus the valid chains and the counter.

Test Plan:
- Reset check: hold rst_ni=0 with random inputs and ensys_i=1 -> all outputs 0. Deassert rst_ni with ensys_i=0 -> outputs stay 0 and busy_o=0.
- Single-word skew:
  - Stimulus: one acc cycle at t0 with a_word lane i = 8'h10+i and b_word lane i = 8'h80+i.
  - Required: a_skew lane i = 8'h10+i and lane_vld_o[i]=1 exactly at t0+1+i, otherwise 0. B behaves identically.
  - Required: busy_o high over t0+1..t0+10.
- Streaming: 10 consecutive acc cycles with A lane i = cycle index j -> a_skew lane i shows j at t0+1+i+j, and lane_vld_o is all-ones only at t0+10.
- Bubble injection: pattern acc,acc,bubble,acc (ensys_i=1) -> lane 3 outputs v0,v1,0,v3 at t0+4..t0+7, with lane_vld_o[3]=1,1,0,1.
- Drain after ensys fall: accept at t0, then ensys_i=0 from t0+1 -> lane 9 still delivers the value at t0+10; busy_o falls at t0+11.
- Reset mid-stream: assert rst_ni=0 at t0+3 after acc at t0 -> all outputs 0 immediately. After release, lanes 3..9 never emit the discarded element.
